// File: rtl/datapath_pkg.sv
// Shared definitions for the multi-cycle datapath controller:
// FSM state encoding, instruction field positions and ALU codes.
package datapath_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB
  } state_t;

  localparam int OP_HI = 15;
  localparam int OP_LO = 12;
  localparam int RD_HI = 11;
  localparam int RD_LO = 8;
  localparam int RS_HI = 7;
  localparam int RS_LO = 4;
  localparam int RT_HI = 3;
  localparam int RT_LO = 0;

  localparam logic [3:0] OP_LOAD = 4'hF;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b010;

endpackage

// File: rtl/datapath_ctrl_instr_decode.sv
// Combinational field extraction and imm4 sign extension
// for one 16-bit instruction word.
module instr_decode
  import datapath_pkg::*;
#(
  parameter int DW = 16
) (
  input  logic [DW-1:0] instr,
  output logic [3:0]    rd,
  output logic [3:0]    rs,
  output logic [3:0]    rt,
  output logic          is_load,
  output logic          is_imm,
  output logic [2:0]    alu_op,
  output logic [DW-1:0] sign_e
);

  logic [3:0] op;

  assign op     = instr[OP_HI:OP_LO];
  assign rd     = instr[RD_HI:RD_LO];
  assign rs     = instr[RS_HI:RS_LO];
  assign rt     = instr[RT_HI:RT_LO];
  assign is_imm = op[3];

  assign is_load = (op == OP_LOAD);

  // Loads compute their address as rs + imm, hence a forced add.
  assign alu_op = is_load ? ALU_ADD : op[2:0];

  assign sign_e = {{(DW-4){rt[3]}}, rt};

endmodule

// File: rtl/datapath_ctrl.sv
// Multi-cycle control FSM: IDLE -> DECODE -> EXEC -> (MEM) -> WB,
// with a bounded wait on MemReady for loads.
module datapath_ctrl
  import datapath_pkg::*;
#(
  parameter int DW          = 16,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic          CLK,
  input  logic          Reset,
  input  logic          Start,
  input  logic [DW-1:0] Instr,
  input  logic          MemReady,
  output logic [3:0]    RA1,
  output logic [3:0]    RA2,
  output logic [3:0]    WA,
  output logic          RW,
  output logic          LM,
  output logic          SrcB,
  output logic [2:0]    ALUOp,
  output logic [DW-1:0] signE,
  output logic          MemReq,
  output logic          Busy,
  output logic          Done,
  output logic          Err
);

  localparam int CW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(MEM_TIMEOUT - 1);

  state_t        state;
  logic [DW-1:0] ir;
  logic [CW-1:0] cnt;

  logic [DW-1:0] src;
  logic [3:0]    rd;
  logic [3:0]    rs;
  logic [3:0]    rt;
  logic          is_load;
  logic          is_imm;
  logic [2:0]    alu_op;
  logic [DW-1:0] sign_e;

  // In IDLE the live Instr is decoded so RA1/RA2 are valid in DECODE.
  assign src = (state == S_IDLE) ? Instr : ir;

  instr_decode #(.DW(DW)) u_dec (
    .instr   (src),
    .rd      (rd),
    .rs      (rs),
    .rt      (rt),
    .is_load (is_load),
    .is_imm  (is_imm),
    .alu_op  (alu_op),
    .sign_e  (sign_e)
  );

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state  <= S_IDLE;
      ir     <= '0;
      cnt    <= '0;
      RA1    <= '0;
      RA2    <= '0;
      WA     <= '0;
      RW     <= 1'b0;
      LM     <= 1'b0;
      SrcB   <= 1'b0;
      ALUOp  <= '0;
      signE  <= '0;
      MemReq <= 1'b0;
      Busy   <= 1'b0;
      Done   <= 1'b0;
      Err    <= 1'b0;
    end else begin
      Err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (Start) begin
            ir    <= Instr;
            RA1   <= rs;
            RA2   <= rt;
            Busy  <= 1'b1;
            state <= S_DECODE;
          end
        end
        S_DECODE: begin
          ALUOp <= alu_op;
          SrcB  <= is_imm;
          signE <= is_imm ? sign_e : '0;
          state <= S_EXEC;
        end
        S_EXEC: begin
          cnt <= '0;
          if (is_load) begin
            MemReq <= 1'b1;
            LM     <= 1'b1;
            state  <= S_MEM;
          end else begin
            RW    <= 1'b1;
            WA    <= rd;
            Done  <= 1'b1;
            LM    <= 1'b0;
            state <= S_WB;
          end
        end
        S_MEM: begin
          if (MemReady) begin
            MemReq <= 1'b0;
            RW     <= 1'b1;
            WA     <= rd;
            Done   <= 1'b1;
            state  <= S_WB;
          end else if (cnt == CNT_LAST) begin
            // Abandon the load: no write-back, single-cycle Err.
            cnt    <= '0;
            RA1    <= '0;
            RA2    <= '0;
            LM     <= 1'b0;
            SrcB   <= 1'b0;
            ALUOp  <= '0;
            signE  <= '0;
            MemReq <= 1'b0;
            Busy   <= 1'b0;
            Err    <= 1'b1;
            state  <= S_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_WB: begin
          RA1   <= '0;
          RA2   <= '0;
          WA    <= '0;
          RW    <= 1'b0;
          LM    <= 1'b0;
          SrcB  <= 1'b0;
          ALUOp <= '0;
          signE <= '0;
          Busy  <= 1'b0;
          Done  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_datapath_ctrl.sv
// Scenario bench for datapath_ctrl with a small RF/ALU model and
// an expected-result queue filled at issue, drained at Done/Err.
module tb_datapath_ctrl;

  localparam logic [15:0] MD_VAL = 16'hBEEF;

  logic        clk;
  logic        reset;
  logic        start;
  logic [15:0] instr;
  logic        mem_ready;
  logic [3:0]  ra1;
  logic [3:0]  ra2;
  logic [3:0]  wa;
  logic        rw;
  logic        lm;
  logic        srcb;
  logic [2:0]  aluop;
  logic [15:0] signe;
  logic        memreq;
  logic        busy;
  logic        done;
  logic        err;

  datapath_ctrl #(.DW(16), .MEM_TIMEOUT(15)) dut (
    .CLK      (clk),
    .Reset    (reset),
    .Start    (start),
    .Instr    (instr),
    .MemReady (mem_ready),
    .RA1      (ra1),
    .RA2      (ra2),
    .WA       (wa),
    .RW       (rw),
    .LM       (lm),
    .SrcB     (srcb),
    .ALUOp    (aluop),
    .signE    (signe),
    .MemReq   (memreq),
    .Busy     (busy),
    .Done     (done),
    .Err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  wa;
    logic        lm;
    logic [2:0]  aluop;
    logic        srcb;
    logic [15:0] signe;
    logic [15:0] data;
    int          cyc;
    logic        err;
  } exp_t;

  typedef struct {
    logic        done;
    logic        err;
    logic        tmo;
    int          viol;
    int          cyc;
    logic [3:0]  wa;
    logic        lm;
    logic        rw;
    logic        busy;
    logic [2:0]  aluop;
    logic        srcb;
    logic [15:0] signe;
    logic [15:0] data;
    logic [2:0]  x_aluop;
    logic        x_srcb;
    logic [15:0] x_signe;
    logic [3:0]  x_ra1;
    logic [3:0]  x_ra2;
  } obs_t;

  exp_t        q[$];
  logic [15:0] rf [16];
  int          n_tests;
  int          n_fail;

  function automatic logic [15:0] alu_model();
    logic [15:0] a;
    logic [15:0] b;
    a = rf[ra1];
    b = srcb ? signe : rf[ra2];
    return (aluop == 3'b010) ? a - b : a + b;
  endfunction

  task automatic run_txn(input logic [15:0] ins,
                         input int rdy_at,
                         output obs_t o);
    int cyc;
    int mcnt;
    o = '{default: '0};
    mcnt = 0;
    @(negedge clk);
    instr = ins;
    start = 1'b1;
    cyc   = 1;
    o.tmo = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      start = 1'b0;
      cyc++;
      if (rw && !done) o.viol++;
      if (rw && err) o.viol++;
      if (cyc == 3) begin
        o.x_aluop = aluop;
        o.x_srcb  = srcb;
        o.x_signe = signe;
        o.x_ra1   = ra1;
        o.x_ra2   = ra2;
      end
      if (memreq) mcnt++;
      mem_ready = memreq && (rdy_at != 0) && (mcnt == rdy_at);
      if (done || err) begin
        o.tmo   = 1'b0;
        o.done  = done;
        o.err   = err;
        o.cyc   = cyc;
        o.wa    = wa;
        o.lm    = lm;
        o.rw    = rw;
        o.busy  = busy;
        o.aluop = aluop;
        o.srcb  = srcb;
        o.signe = signe;
        if (done) begin
          o.data = lm ? MD_VAL : alu_model();
          if (rw) rf[wa] = o.data;
        end
        break;
      end
    end
    mem_ready = 1'b0;
  endtask

  task automatic check_wb(input string name, input obs_t o);
    exp_t e;
    if (q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s scoreboard empty", name);
      return;
    end
    e = q.pop_front();
    n_tests++;
    if (o.tmo || o.done !== 1'b1) begin
      n_fail++;
      $display("FAIL %s done: got done=%b tmo=%b want done=1",
               name, o.done, o.tmo);
      return;
    end
    n_tests++;
    if (o.cyc !== e.cyc) begin
      n_fail++;
      $display("FAIL %s latency: got %0d want %0d", name, o.cyc, e.cyc);
    end
    n_tests++;
    if (o.wa !== e.wa || o.rw !== 1'b1) begin
      n_fail++;
      $display("FAIL %s write: got wa=%0d rw=%b want wa=%0d rw=1",
               name, o.wa, o.rw, e.wa);
    end
    n_tests++;
    if (o.lm !== e.lm) begin
      n_fail++;
      $display("FAIL %s lm: got %b want %b", name, o.lm, e.lm);
    end
    n_tests++;
    if (o.x_aluop !== e.aluop || o.x_srcb !== e.srcb ||
        o.x_signe !== e.signe) begin
      n_fail++;
      $display("FAIL %s exec: got op=%b srcb=%b se=%h want op=%b srcb=%b se=%h",
               name, o.x_aluop, o.x_srcb, o.x_signe,
               e.aluop, e.srcb, e.signe);
    end
    n_tests++;
    if (o.aluop !== e.aluop || o.srcb !== e.srcb ||
        o.signe !== e.signe) begin
      n_fail++;
      $display("FAIL %s wb hold: got op=%b srcb=%b se=%h want op=%b srcb=%b se=%h",
               name, o.aluop, o.srcb, o.signe,
               e.aluop, e.srcb, e.signe);
    end
    n_tests++;
    if (o.data !== e.data) begin
      n_fail++;
      $display("FAIL %s data: got %h want %h", name, o.data, e.data);
    end
    n_tests++;
    if (o.viol != 0) begin
      n_fail++;
      $display("FAIL %s rw_outside_wb: got %0d want 0", name, o.viol);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    instr = '0;
    mem_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if ({ra1, ra2, wa, rw, lm, srcb, aluop, signe,
         memreq, busy, done, err} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got ra1=%0d ra2=%0d wa=%0d rw=%b lm=%b busy=%b done=%b err=%b want all 0",
               ra1, ra2, wa, rw, lm, busy, done, err);
    end
    reset = 1'b0;
  endtask

  task automatic test_sub();
    obs_t o;
    rf[1] = 16'd4;
    rf[2] = 16'd2;
    q.push_back('{wa: 4'd3, lm: 1'b0, aluop: 3'b010, srcb: 1'b0,
                  signe: 16'h0, data: 16'h0002, cyc: 4, err: 1'b0});
    run_txn(16'h2312, 0, o);
    n_tests++;
    if (o.x_ra1 !== 4'd1 || o.x_ra2 !== 4'd2) begin
      n_fail++;
      $display("FAIL sub_ra: got ra1=%0d ra2=%0d want 1 2",
               o.x_ra1, o.x_ra2);
    end
    check_wb("sub", o);
  endtask

  task automatic test_addi();
    obs_t o;
    rf[1] = 16'd8;
    q.push_back('{wa: 4'd4, lm: 1'b0, aluop: 3'b000, srcb: 1'b1,
                  signe: 16'h0000, data: 16'h0008, cyc: 4, err: 1'b0});
    run_txn(16'h8410, 0, o);
    check_wb("addi", o);
  endtask

  task automatic test_sext();
    obs_t o;
    rf[1] = 16'd8;
    q.push_back('{wa: 4'd5, lm: 1'b0, aluop: 3'b000, srcb: 1'b1,
                  signe: 16'hFFFF, data: 16'h0007, cyc: 4, err: 1'b0});
    run_txn(16'h851F, 0, o);
    check_wb("sext", o);
  endtask

  task automatic test_rd0();
    obs_t o;
    rf[1] = 16'd4;
    rf[2] = 16'd2;
    q.push_back('{wa: 4'd0, lm: 1'b0, aluop: 3'b000, srcb: 1'b0,
                  signe: 16'h0, data: 16'h0006, cyc: 4, err: 1'b0});
    run_txn(16'h0012, 0, o);
    check_wb("rd0", o);
  endtask

  task automatic test_load();
    obs_t o;
    q.push_back('{wa: 4'd5, lm: 1'b1, aluop: 3'b000, srcb: 1'b1,
                  signe: 16'h0000, data: MD_VAL, cyc: 7, err: 1'b0});
    run_txn(16'hF510, 3, o);
    check_wb("load", o);
  endtask

  task automatic test_timeout();
    obs_t o;
    exp_t e;
    q.push_back('{wa: 4'd0, lm: 1'b0, aluop: 3'b000, srcb: 1'b0,
                  signe: 16'h0, data: 16'h0, cyc: 19, err: 1'b1});
    run_txn(16'hF510, 0, o);
    e = q.pop_front();
    n_tests++;
    if (o.tmo || o.err !== e.err || o.done !== 1'b0) begin
      n_fail++;
      $display("FAIL tmo_err: got err=%b done=%b tmo=%b want err=1 done=0",
               o.err, o.done, o.tmo);
    end
    n_tests++;
    if (o.cyc !== e.cyc) begin
      n_fail++;
      $display("FAIL tmo_latency: got %0d want %0d", o.cyc, e.cyc);
    end
    n_tests++;
    if (o.rw !== 1'b0 || o.busy !== 1'b0 || o.viol != 0) begin
      n_fail++;
      $display("FAIL tmo_state: got rw=%b busy=%b viol=%0d want 0 0 0",
               o.rw, o.busy, o.viol);
    end
    @(negedge clk);
    n_tests++;
    if (err !== 1'b0) begin
      n_fail++;
      $display("FAIL tmo_pulse: got err=%b want 0", err);
    end
  endtask

  task automatic test_back_to_back();
    int ndone;
    ndone = 0;
    rf[1] = 16'd4;
    rf[2] = 16'd2;
    @(negedge clk);
    instr = 16'h2312;
    start = 1'b1;
    for (int c = 2; c <= 14; c++) begin
      @(negedge clk);
      if (c == 5) start = 1'b0;
      if (done) ndone++;
    end
    n_tests++;
    if (ndone != 1) begin
      n_fail++;
      $display("FAIL b2b_done_count: got %0d want 1", ndone);
    end
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_idle: got busy=%b want 0", busy);
    end
  endtask

  task automatic test_reset_mid();
    int ndone;
    ndone = 0;
    @(negedge clk);
    instr = 16'h2312;
    start = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_tests++;
    if ({ra1, ra2, wa, rw, lm, srcb, aluop, signe,
         memreq, busy, done, err} !== '0) begin
      n_fail++;
      $display("FAIL midreset_outputs: got busy=%b aluop=%b ra1=%0d rw=%b want all 0",
               busy, aluop, ra1, rw);
    end
    reset = 1'b0;
    start = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (done || rw) ndone++;
    end
    n_tests++;
    if (ndone != 0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_no_write: got writes=%0d busy=%b want 0 0",
               ndone, busy);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    for (int i = 0; i < 16; i++) rf[i] = '0;
    test_reset();
    test_sub();
    test_addi();
    test_sext();
    test_rd0();
    test_load();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/datapath_ctrl.md
DATAPATH_CTRL -- requirements
Module: datapath_ctrl

Interface
REQ-001 SHALL have parameter: DW, 16, datapath word width.
REQ-002 SHALL have parameter: MEM_TIMEOUT, 15, maximum cycles to wait for MemReady on a load.
REQ-003 SHALL have port: CLK  in  1  the only clock; all state updates on rising edge.
REQ-004 SHALL have port: Reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have port: Start  in  1  request to execute Instr; sampled only in IDLE.
REQ-006 SHALL have port: Instr  in  DW  instruction [15:12] op, [11:8] rd, [7:4] rs, [3:0] rt/imm4.
REQ-007 SHALL have port: MemReady  in  1  memory data valid on the MD path.
REQ-008 SHALL have ports: RA1, RA2, WA  out  4 each  register-file read/write addresses.
REQ-009 SHALL have port: RW  out  1  register-file write enable.
REQ-010 SHALL have ports: LM  out  1  write-back select (1 = MD, 0 = ALUO); SrcB  out  1  ALU B select (1 = signE).
REQ-011 SHALL have ports: ALUOp  out  3  ALU operation; signE  out  DW  sign-extended imm4.
REQ-012 SHALL have ports: MemReq  out  1; Busy  out  1; Done  out  1; Err  out  1.

Function
REQ-013 SHALL implement states IDLE, DECODE, EXEC, MEM, WB; all outputs registered.
REQ-014 IDLE: on Start=1, SHALL latch Instr and go to DECODE; Busy=1 from the next cycle until return to IDLE.
REQ-015 DECODE (1 cycle): SHALL drive RA1=rs, RA2=rt; go to EXEC.
REQ-016 EXEC (1 cycle): op[3]=0 -> ALUOp=op[2:0], SrcB=0; op[3]=1 and op!=4'hF -> ALUOp=op[2:0], SrcB=1, signE=sext(imm4).
REQ-017 op=4'hF is a load: SHALL drive ALUOp=000, SrcB=1, signE=sext(imm4), then go to MEM; all other ops go to WB.
REQ-018 MEM: SHALL assert MemReq=1 and LM=1; MemReady=1 (including the first MEM cycle) -> WB next cycle.
REQ-019 MEM: a counter SHALL expire after MEM_TIMEOUT cycles without MemReady -> pulse Err for 1 cycle, no write, return to IDLE.
REQ-020 WB (1 cycle): SHALL assert RW=1, WA=rd, Done=1 for exactly that cycle; LM held from MEM for loads, else 0; then go to IDLE.
REQ-021 Latency: ALU ops SHALL complete with Done in the 4th cycle after Start is sampled (IDLE->DECODE->EXEC->WB); loads take 4 + MEM wait cycles.
REQ-022 Start while Busy SHALL be ignored, not queued; Start in the WB cycle is also ignored.
REQ-023 ALUOp, SrcB, signE, RA1 and RA2 SHALL hold stable from EXEC through WB.
REQ-024 RW SHALL never be 1 outside WB, and never in a cycle in which Err=1.
REQ-025 rd=0 SHALL be an ordinary writable register (no hardwired zero).

Reset
REQ-026 Reset=1 at a rising edge SHALL force IDLE and clear all outputs to 0, the timeout counter, and the latched instruction, including mid-operation (no write issued).
REQ-027 Reset SHALL take priority over Start and MemReady in the same cycle.

Structure
REQ-028 State encoding, opcode field positions, LOAD opcode (4'hF), and ALUOp codes (000 add, 010 sub) SHALL live in a shared package datapath_pkg.
REQ-029 Field extraction and sign extension SHALL be one combinational sub-module, instr_decode; the FSM and counter stay in datapath_ctrl.

Verification
REQ-030 Sub: R1=4, R2=2 preloaded in the RF; Instr=16'h2312, Start -> EXEC ALUOp=010 SrcB=0, WB RW=1 WA=3, ALUO=16'h0002, Done at cycle 4.
REQ-031 Add immediate: Instr=16'h8410, R1=8 -> ALUOp=000, SrcB=1, signE=16'h0000, WB WA=4, ALUO=16'h0008.
REQ-032 Sign extension: Instr=16'h851F -> signE=16'hFFFF.
REQ-033 Load: Instr=16'hF510, MemReady asserted 3 cycles after MemReq -> LM=1, RW=1, WA=5, Done at cycle 7.
REQ-034 Load timeout: MemReady held 0 -> Err pulses after 15 MEM cycles; RW stays 0; Busy drops.
REQ-035 Reset in EXEC and a second Start while Busy -> IDLE on the next edge with all outputs 0; the second Start produces no Done.
